// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants, encodings and state type for the ECC ladder sequencer.
package ecc_pkg;
   localparam int MAX_BITS = 256;
   typedef enum logic [1:0] {BITS32, BITS64, BITS128, BITS256} mode_e;
   typedef enum logic [1:0] {OP_LOAD, OP_DBL, OP_ADD} op_e;
   typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, DONE} state_e;
   function automatic int width_top(input logic [1:0] mode);
      return (32 << mode) - 1;
   endfunction
endpackage

// File: rtl/ecc_mode_mask.sv
// ecc_mode_mask: masks the scalar to the selected width and reports its top bit index.
module ecc_mode_mask #(
   parameter int MAX_BITS = ecc_pkg::MAX_BITS,
   parameter int IDX_W = 8
) (
   input  logic [1:0]          mode,
   input  logic [MAX_BITS-1:0] k,
   output logic [MAX_BITS-1:0] k_masked,
   output logic [IDX_W-1:0]    top
);
   import ecc_pkg::*;
   always_comb begin
      int t;
      t = width_top(mode);
      top = IDX_W'(t);
      k_masked = k & ({MAX_BITS{1'b1}} >> (MAX_BITS - 1 - t));
   end
endmodule

// File: rtl/ecc_ladder_ctrl.sv
// ecc_ladder_ctrl: MSB-first double-and-add command sequencer for the point-arithmetic unit.
// Define ECC_CONST_TIME_EN for a fixed 2*width-1 command stream with dummy-flagged ops.
module ecc_ladder_ctrl #(
   parameter int MAX_BITS = ecc_pkg::MAX_BITS,
   parameter int IDX_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic [1:0]          i_mode,
   input  logic [MAX_BITS-1:0] i_k,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_inf,
   output logic                o_op_valid,
   output logic [1:0]          o_op_code,
   output logic                o_op_dummy,
   input  logic                i_op_ready,
   input  logic                i_op_done
);
   import ecc_pkg::*;
   state_e state, state_n;
   op_e pend, pend_n;
   logic [IDX_W-1:0] idx, idx_n, top;
   logic [MAX_BITS-1:0] k_r, k_n, k_masked;
   logic inf, inf_n, fin;
`ifdef ECC_CONST_TIME_EN
   logic dummy, dummy_n, started, started_n, add_slot, add_slot_n;
`endif
   ecc_mode_mask #(.MAX_BITS(MAX_BITS), .IDX_W(IDX_W)) u_mask (
      .mode(i_mode),
      .k(i_k),
      .k_masked(k_masked),
      .top(top)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pend <= OP_LOAD;
         idx <= '0;
         k_r <= '0;
         inf <= 1'b0;
`ifdef ECC_CONST_TIME_EN
         dummy <= 1'b0;
         started <= 1'b0;
         add_slot <= 1'b0;
`endif
      end else begin
         state <= state_n;
         pend <= pend_n;
         idx <= idx_n;
         k_r <= k_n;
         inf <= inf_n;
`ifdef ECC_CONST_TIME_EN
         dummy <= dummy_n;
         started <= started_n;
         add_slot <= add_slot_n;
`endif
      end
   end
   always_comb begin
      state_n = state;
      pend_n = pend;
      idx_n = idx;
      k_n = k_r;
      inf_n = inf;
      fin = 1'b0;
`ifdef ECC_CONST_TIME_EN
      dummy_n = dummy;
      started_n = started;
      add_slot_n = add_slot;
`endif
      case (state)
         IDLE: if (i_start) begin
            state_n = SCAN;
            k_n = k_masked;
            idx_n = top;
            inf_n = 1'b0;
         end
`ifdef ECC_CONST_TIME_EN
         SCAN: begin
            state_n = ISSUE;
            pend_n = k_r[idx] ? OP_LOAD : OP_DBL;
            dummy_n = !k_r[idx];
            started_n = k_r[idx];
            add_slot_n = 1'b1;
         end
`else
         SCAN: if (k_r[idx]) begin
            pend_n = OP_LOAD;
            state_n = ISSUE;
         end else if (idx == '0) begin
            inf_n = 1'b1;
            state_n = DONE;
         end else
            idx_n = idx - IDX_W'(1);
`endif
         ISSUE: if (i_op_ready) begin
            state_n = WAIT;
            fin = i_op_done;
         end
         WAIT: fin = i_op_done;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // a finished command (possibly in its accept cycle) selects the next step
      if (fin) begin
`ifdef ECC_CONST_TIME_EN
         if (!add_slot) begin
            state_n = ISSUE;
            add_slot_n = 1'b1;
            pend_n = (k_r[idx] && !started) ? OP_LOAD : OP_ADD;
            dummy_n = !k_r[idx];
            started_n = started | k_r[idx];
         end else if (idx == '0) begin
            state_n = DONE;
            inf_n = !started;
         end else begin
            state_n = ISSUE;
            add_slot_n = 1'b0;
            idx_n = idx - IDX_W'(1);
            pend_n = OP_DBL;
            dummy_n = !started;
         end
`else
         if (pend == OP_DBL && k_r[idx]) begin
            pend_n = OP_ADD;
            state_n = ISSUE;
         end else if (idx == '0)
            state_n = DONE;
         else begin
            idx_n = idx - IDX_W'(1);
            pend_n = OP_DBL;
            state_n = ISSUE;
         end
`endif
      end
   end
   assign o_busy = state != IDLE;
   assign o_done = state == DONE;
   assign o_inf = inf;
   assign o_op_valid = state == ISSUE;
   assign o_op_code = o_op_valid ? pend : OP_LOAD;
`ifdef ECC_CONST_TIME_EN
   assign o_op_dummy = o_op_valid & dummy;
`else
   assign o_op_dummy = 1'b0;
`endif
endmodule

// File: doc/ecc_ladder_ctrl.md
# ecc_ladder_ctrl

Sequencer for the elliptic-curve scalar-multiplication datapath. It takes a scalar `k` and a width mode, scans `k` MSB-first, and issues a left-to-right double-and-add command stream (LOAD, DBL, ADD) to the point-arithmetic unit over a valid/ready/done handshake. It sits between the serial I/O wrapper, which supplies `k` and mode, and the point-arithmetic core, which holds all point registers. The block holds no coordinates.

## Interface
Parameters:
- MAX_BITS, 256, maximum scalar width.
- IDX_W, 8, bit-index counter width (log2 of MAX_BITS).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_mode  in  2  width select: 0=32, 1=64, 2=128, 3=256 bits.
- i_k  in  MAX_BITS  scalar; bits above the mode width are ignored.
- o_busy  out  1  high whenever the state is not IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_inf  out  1  result is the point at infinity; valid while o_done is high, held until the next start.
- o_op_valid  out  1  command valid.
- o_op_code  out  2  0=LOAD (acc←P), 1=DBL (acc←2·acc), 2=ADD (acc←acc+P).
- o_op_dummy  out  1  datapath must discard this result (see Configuration).
- i_op_ready  in  1  datapath accepts the command this cycle.
- i_op_done  in  1  one-cycle pulse; the accepted command has finished.

## Operation
- States: IDLE, SCAN, ISSUE, WAIT, DONE.
- IDLE, when i_start=1:
  - latch k masked to the mode width, and latch the mode;
  - set idx = width−1, clear o_inf;
  - go to SCAN.
- SCAN examines one bit per cycle:
  - k[idx]=1: set pending op = LOAD and go to ISSUE.
  - k[idx]=0 and idx=0: set o_inf=1 and go to DONE.
  - Otherwise decrement idx.
- ISSUE:
  - o_op_valid=1 and o_op_code=pending, both held stable until a cycle with i_op_ready=1.
  - That cycle is the accept; go to WAIT with o_op_valid=0.
- WAIT: on i_op_done, the next step depends on the op that just finished.
  - After LOAD or ADD: if idx=0, go to DONE; else decrement idx, set pending=DBL, go to ISSUE.
  - After DBL: if k[idx]=1, set pending=ADD and go to ISSUE; else if idx=0, go to DONE; else decrement idx, set pending=DBL, go to ISSUE.
- DONE: o_done=1 for one cycle, then go to IDLE.
- Only one outstanding command at a time.
- i_op_done outside WAIT is ignored.
- i_start outside IDLE is ignored; latched k and mode are unaffected.
- i_k and i_mode may change freely after the start cycle.
- Mode width lookup: 32/64/128/256, giving top index 31/63/127/255.

## Timing
- Reset values: o_busy=0, o_done=0, o_inf=0, o_op_valid=0, o_op_code=0, o_op_dummy=0. State is IDLE and idx=0.
- Reset asserted mid-operation:
  - returns the block to IDLE on the next edge;
  - drops o_op_valid in that same edge;
  - a later i_op_done is ignored.
- Start to first o_op_valid: 1 + (number of leading zeros of k within the width) + 1 cycles.
- o_op_valid rises the cycle after entering ISSUE, so an accept may occur in the same cycle it rises.
- An i_op_done in the same cycle as the accept is legal: the block goes straight from ISSUE to the next ISSUE or DONE, with no WAIT cycle.
- Last i_op_done to o_done: 1 cycle.
- o_busy falls in the cycle after o_done.
- k=0: o_done at start + 1 + width cycles, with o_inf=1 and no commands issued.

## Configuration
- ECC_CONST_TIME_EN defined:
  - Leading zeros are not skipped silently. Each zero bit scanned before the first 1 issues a DBL with o_op_dummy=1.
  - Each zero bit after the first 1 issues an ADD with o_op_dummy=1 after its DBL.
  - Command count is therefore 2·width−1 for any nonzero k.
  - k=0 issues 2·width−1 dummy-flagged commands, then o_inf=1.
- ECC_CONST_TIME_EN undefined: behaviour exactly as in Operation, and o_op_dummy is tied 0.

## Structure
- Shared package `ecc_pkg` holds:
  - MAX_BITS;
  - mode encodings BITS32/64/128/256;
  - op codes OP_LOAD/OP_DBL/OP_ADD;
  - the state enumeration;
  - a width-to-top-index function.
- Sub-module `ecc_mode_mask`: combinational mask of k to the mode width, plus the top-index output.
- The FSM, idx counter and handshake logic live in this block.

## Test plan
- Mode 0, k=0x5, i_op_ready held 1, i_op_done 3 cycles after each accept:
  - ops are LOAD, DBL, DBL, ADD;
  - o_done with o_inf=0;
  - first o_op_valid 31 cycles after start.
- Mode 0, k=0x1_0000_0000 (bit above width):
  - no ops issued;
  - o_done at start+33 with o_inf=1.
- Mode 3, k=2^255+1:
  - LOAD, then 255 DBLs, then ADD only after the final DBL;
  - exactly 257 accepts.
- Backpressure: i_op_ready low for 5 cycles:
  - o_op_valid and o_op_code held stable;
  - a second i_start and a spurious i_op_done in ISSUE change nothing.
- rst pulsed in WAIT of mode 1, k=0xFF:
  - next cycle IDLE with all outputs at reset values;
  - a new start with k=0x3 yields LOAD, DBL, ADD.
- With ECC_CONST_TIME_EN, mode 0, k=0x5: 63 commands total, with o_op_dummy set on exactly the dummy DBL/ADD positions.
